// File: rtl/irq_ctrl_pkg.sv
// Shared types and register map for the irq_ctrl interrupt controller.
// RF_XLEN falls back to 32 when the core's config header has not defined it.
`ifndef RF_XLEN
`define RF_XLEN 32
`endif

package irq_pkg;

  localparam int XLEN        = `RF_XLEN;
  localparam int DEF_NUM_SRC = 8;
  localparam int DEF_PRIO_W  = 3;
  localparam int ID_W_MAX    = 5;

  typedef enum logic {
    IDLE    = 1'b0,
    SERVICE = 1'b1
  } state_t;

  typedef logic [5:0]            cfg_addr_t;
  typedef logic [DEF_PRIO_W-1:0] prio_t;
  typedef logic [ID_W_MAX-1:0]   id_t;

  localparam cfg_addr_t REG_EN   = 6'd0;
  localparam cfg_addr_t REG_PEND = 6'd1;
  localparam cfg_addr_t REG_THR  = 6'd2;
  localparam cfg_addr_t REG_ACT  = 6'd3;
  localparam cfg_addr_t REG_EDGE = 6'd4;
  localparam cfg_addr_t REG_PRIO = 6'd8;

endpackage

// File: rtl/irq_ctrl_if.sv
// Peripheral-line, config-bus and claim/complete signals between the core side and irq_ctrl.
// The master modport is the core/trap-handler side, the slave modport is the controller.
interface irq_ctrl_if
  import irq_pkg::*;
#(
  parameter int NUM_SRC = DEF_NUM_SRC,
  parameter int ID_W    = $clog2(NUM_SRC + 1)
);

  logic [NUM_SRC-1:0] src_irq;
  logic               cfg_wr;
  cfg_addr_t          cfg_addr;
  logic [XLEN-1:0]    cfg_wdata;
  logic [XLEN-1:0]    cfg_rdata;
  logic               irq;
  logic               claim;
  logic [ID_W-1:0]    claim_id;
  logic               complete;
  logic [ID_W-1:0]    complete_id;

  modport master (
    output src_irq, cfg_wr, cfg_addr, cfg_wdata, claim, complete, complete_id,
    input  cfg_rdata, irq, claim_id
  );

  modport slave (
    input  src_irq, cfg_wr, cfg_addr, cfg_wdata, claim, complete, complete_id,
    output cfg_rdata, irq, claim_id
  );

endinterface

// File: rtl/irq_ctrl_arbiter.sv
// Combinational priority-compare tree: highest priority among eligible sources, lowest index on ties.
// Returns id 0 / prio 0 when nothing is eligible.
module irq_arbiter
  import irq_pkg::*;
#(
  parameter int NUM_SRC = DEF_NUM_SRC,
  parameter int PRIO_W  = DEF_PRIO_W,
  parameter int ID_W    = $clog2(NUM_SRC + 1)
) (
  input  logic [NUM_SRC-1:0]        elig,
  input  logic [NUM_SRC*PRIO_W-1:0] prio_vec,
  output logic [ID_W-1:0]           win_id,
  output logic [PRIO_W-1:0]         win_prio
);

  localparam int LEAVES = (NUM_SRC < 2) ? 1 : (1 << $clog2(NUM_SRC));
  localparam int NODES  = 2 * LEAVES - 1;

  // Heap-ordered tree: left children always cover lower source indices, so ">=" keeps the lower index.
  function automatic logic [ID_W+PRIO_W-1:0] tree_pick(
    input logic [NUM_SRC-1:0]        e,
    input logic [NUM_SRC*PRIO_W-1:0] pv
  );
    logic [PRIO_W-1:0] np [NODES];
    logic [ID_W-1:0]   ni [NODES];
    for (int k = 0; k < NODES; k++) begin
      np[k] = '0;
      ni[k] = '0;
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      if (e[i]) begin
        np[LEAVES-1+i] = pv[i*PRIO_W +: PRIO_W];
        ni[LEAVES-1+i] = ID_W'(i + 1);
      end
    end
    for (int k = LEAVES - 2; k >= 0; k--) begin
      if (np[2*k+1] >= np[2*k+2]) begin
        np[k] = np[2*k+1];
        ni[k] = ni[2*k+1];
      end else begin
        np[k] = np[2*k+2];
        ni[k] = ni[2*k+2];
      end
    end
    return {ni[0], np[0]};
  endfunction

  assign {win_id, win_prio} = tree_pick(elig, prio_vec);

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: NUM_SRC prioritised, maskable interrupt sources with claim/complete; irq is 2 cycles after src_irq.
// Define IRQ_CTRL_EDGE_EN to add per-source rising-edge mode (edge mask at register 4).
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int NUM_SRC = DEF_NUM_SRC,
  parameter int PRIO_W  = DEF_PRIO_W,
  parameter int ID_W    = $clog2(NUM_SRC + 1)
) (
  input logic       clk,
  input logic       rst,
  irq_ctrl_if.slave bus
);

  logic [NUM_SRC-1:0]        en_q, pend_q, pend_d, elig;
  logic [PRIO_W-1:0]         thr_q;
  logic [PRIO_W-1:0]         prio_q [NUM_SRC];
  logic [NUM_SRC*PRIO_W-1:0] prio_vec;
  state_t                    state_q;
  logic [ID_W-1:0]           act_q, best_id_q, arb_id, nxt_act;
  logic [PRIO_W-1:0]         arb_prio;
  logic                      irq_q, claim_ok, done_ok, nxt_svc;
  logic [XLEN-1:0]           rdata;
  logic                      unused_wdata;

`ifdef IRQ_CTRL_EDGE_EN
  logic [NUM_SRC-1:0] edge_q, prev_q, wr_clr;
`endif

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    assign prio_vec[g*PRIO_W +: PRIO_W] = prio_q[g];
    assign elig[g] = pend_q[g] && en_q[g] && (prio_q[g] > thr_q);
  end

  irq_arbiter #(
    .NUM_SRC (NUM_SRC),
    .PRIO_W  (PRIO_W),
    .ID_W    (ID_W)
  ) u_arb (
    .elig     (elig),
    .prio_vec (prio_vec),
    .win_id   (arb_id),
    .win_prio (arb_prio)
  );

  // irq_q is only ever set for the IDLE state, so it doubles as the claim qualifier.
  always_comb begin
    claim_ok = bus.claim && irq_q;
    done_ok  = (state_q == SERVICE) && bus.complete && (bus.complete_id == act_q);
    nxt_svc  = claim_ok || ((state_q == SERVICE) && !done_ok);
    nxt_act  = claim_ok ? best_id_q : act_q;
    pend_d   = '0;
`ifdef IRQ_CTRL_EDGE_EN
    wr_clr = (bus.cfg_wr && (bus.cfg_addr == REG_PEND)) ? bus.cfg_wdata[NUM_SRC-1:0] : '0;
`endif
    for (int i = 0; i < NUM_SRC; i++) begin
      pend_d[i] = bus.src_irq[i] && !(nxt_svc && (nxt_act == ID_W'(i + 1)));
`ifdef IRQ_CTRL_EDGE_EN
      // Edge sources latch until claimed or written 1; a fresh edge beats the clear.
      if (edge_q[i]) begin
        pend_d[i] = (bus.src_irq[i] && !prev_q[i]) ||
                    (pend_q[i] && !wr_clr[i] && !(claim_ok && (best_id_q == ID_W'(i + 1))));
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      en_q      <= '0;
      thr_q     <= '0;
      pend_q    <= '0;
      act_q     <= '0;
      best_id_q <= '0;
      irq_q     <= 1'b0;
      for (int i = 0; i < NUM_SRC; i++) prio_q[i] <= '0;
`ifdef IRQ_CTRL_EDGE_EN
      edge_q <= '0;
      prev_q <= '0;
`endif
    end else begin
      state_q   <= nxt_svc ? SERVICE : IDLE;
      act_q     <= nxt_act;
      pend_q    <= pend_d;
      best_id_q <= arb_id;
      irq_q     <= !nxt_svc && (arb_prio > thr_q);
`ifdef IRQ_CTRL_EDGE_EN
      prev_q <= bus.src_irq;
`endif
      if (bus.cfg_wr) begin
        case (bus.cfg_addr)
          REG_EN:   en_q   <= bus.cfg_wdata[NUM_SRC-1:0];
          REG_THR:  thr_q  <= bus.cfg_wdata[PRIO_W-1:0];
`ifdef IRQ_CTRL_EDGE_EN
          REG_EDGE: edge_q <= bus.cfg_wdata[NUM_SRC-1:0];
`endif
          default: ;
        endcase
        for (int i = 0; i < NUM_SRC; i++) begin
          if (bus.cfg_addr == cfg_addr_t'(REG_PRIO + i)) prio_q[i] <= bus.cfg_wdata[PRIO_W-1:0];
        end
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (bus.cfg_addr)
      REG_EN:   rdata[NUM_SRC-1:0] = en_q;
      REG_PEND: rdata[NUM_SRC-1:0] = pend_q;
      REG_THR:  rdata[PRIO_W-1:0]  = thr_q;
      REG_ACT:  rdata[ID_W-1:0]    = act_q;
`ifdef IRQ_CTRL_EDGE_EN
      REG_EDGE: rdata[NUM_SRC-1:0] = edge_q;
`endif
      default: ;
    endcase
    for (int i = 0; i < NUM_SRC; i++) begin
      if (bus.cfg_addr == cfg_addr_t'(REG_PRIO + i)) rdata[PRIO_W-1:0] = prio_q[i];
    end
  end

  assign bus.cfg_rdata = rdata;
  assign bus.irq       = irq_q;
  assign bus.claim_id  = (state_q == IDLE) ? best_id_q : act_q;
  assign unused_wdata  = ^bus.cfg_wdata;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: cycle model from the interrupt rules checked every cycle, plus literal pins.
module tb_irq_ctrl;

  logic clk;
  logic rst;

  irq_ctrl_if #(.NUM_SRC(8), .ID_W(4)) bus ();

  irq_ctrl #(.NUM_SRC(8), .PRIO_W(3), .ID_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
  endtask

  // Model state: register contents plus the registered outputs the rules imply.
  int m_en, m_pend, m_thr, m_act, m_edge, m_prev, m_best;
  int m_prio [8];
  bit m_svc, m_irq;
  bit started = 1'b0;

  function automatic int m_read(int a);
    if (a == 0) return m_en;
    if (a == 1) return m_pend;
    if (a == 2) return m_thr;
    if (a == 3) return m_act;
    if (a == 4) return m_edge;
    if (a >= 8 && a < 16) return m_prio[a-8];
    return 0;
  endfunction

  always @(posedge clk) begin
    int src, a, d, bid, bp, nsvc, nact, npend, wclr, s, p, ok_claim, ok_done;
    src = int'(bus.src_irq);
    a   = int'(bus.cfg_addr);
    d   = int'(bus.cfg_wdata);
    if (rst) begin
      m_en = 0; m_pend = 0; m_thr = 0; m_act = 0; m_edge = 0; m_prev = 0; m_best = 0;
      m_svc = 0; m_irq = 0;
      for (int i = 0; i < 8; i++) m_prio[i] = 0;
      started = 1'b1;
    end else begin
      bid = 0;
      bp  = 0;
      for (int i = 0; i < 8; i++) begin
        if (((m_pend >> i) & 1) != 0 && ((m_en >> i) & 1) != 0 && m_prio[i] > m_thr && m_prio[i] > bp) begin
          bp  = m_prio[i];
          bid = i + 1;
        end
      end
      ok_claim = (bus.claim && m_irq) ? 1 : 0;
      ok_done  = (m_svc && bus.complete && int'(bus.complete_id) == m_act) ? 1 : 0;
      nsvc = (ok_claim != 0) ? 1 : ((ok_done != 0) ? 0 : int'(m_svc));
      nact = (ok_claim != 0) ? m_best : m_act;
      wclr = (bus.cfg_wr && a == 1) ? d : 0;
      npend = 0;
      for (int i = 0; i < 8; i++) begin
        s = (src >> i) & 1;
        p = (s != 0 && !(nsvc != 0 && nact == i + 1)) ? 1 : 0;
`ifdef IRQ_CTRL_EDGE_EN
        if (((m_edge >> i) & 1) != 0) begin
          p = ((s != 0 && ((m_prev >> i) & 1) == 0) ||
               (((m_pend >> i) & 1) != 0 && ((wclr >> i) & 1) == 0 &&
                !(ok_claim != 0 && m_best == i + 1))) ? 1 : 0;
        end
`endif
        npend = npend | (p << i);
      end
      if (bus.cfg_wr) begin
        if (a == 0) m_en = d & 'hff;
        else if (a == 2) m_thr = d & 7;
`ifdef IRQ_CTRL_EDGE_EN
        else if (a == 4) m_edge = d & 'hff;
`endif
        else if (a >= 8 && a < 16) m_prio[a-8] = d & 7;
      end
      m_prev = src;
      m_pend = npend;
      m_svc  = (nsvc != 0);
      m_act  = nact;
      m_irq  = (nsvc == 0) && (bid != 0);
      m_best = bid;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("model_irq", bus.irq, m_irq);
      chk("model_claim_id", bus.claim_id, m_svc ? m_act : m_best);
      chk("model_rdata", bus.cfg_rdata, m_read(int'(bus.cfg_addr)));
    end
  end

  task automatic cyc(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(int a, int d);
    bus.cfg_wr    = 1'b1;
    bus.cfg_addr  = 6'(a);
    bus.cfg_wdata = 32'(d);
    cyc();
    bus.cfg_wr    = 1'b0;
  endtask

  task automatic rd(string name, int a, int e);
    bus.cfg_addr = 6'(a);
    #1;
    chk(name, bus.cfg_rdata, e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end, required completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.src_irq = '0; bus.cfg_wr = 0; bus.cfg_addr = '0; bus.cfg_wdata = '0;
    bus.claim = 0; bus.complete = 0; bus.complete_id = '0;
    cyc(2);
    chk("rst_irq", bus.irq, 0);
    chk("rst_claim_id", bus.claim_id, 0);
    rd("rst_en", 0, 0);
    rd("rst_pend", 1, 0);
    rd("rst_thr", 2, 0);
    rst = 1'b0;

    // Basic flow on source 0
    wr(0, 1); wr(8, 3); wr(2, 0);
    bus.src_irq = 8'h01;
    cyc();
    chk("t1_irq_n1", bus.irq, 0);
    rd("t1_pend_n1", 1, 1);
    cyc();
    chk("t1_irq_n2", bus.irq, 1);
    chk("t1_id_n2", bus.claim_id, 1);
    bus.claim = 1; cyc(); bus.claim = 0;
    chk("t1_irq_after_claim", bus.irq, 0);
    chk("t1_id_service", bus.claim_id, 1);
    rd("t1_pend_active", 1, 0);
    rd("t1_active", 3, 1);
    bus.complete = 1; bus.complete_id = 4'd1; cyc(); bus.complete = 0;
    chk("t1_irq_m1", bus.irq, 0);
    cyc();
    chk("t1_irq_m2", bus.irq, 1);
    bus.src_irq = 8'h00;
    cyc(3);

    // Tie-break between sources 2 and 5
    wr(0, 'h24); wr(10, 4); wr(13, 4); wr(2, 1);
    bus.src_irq = 8'h24;
    cyc(2);
    chk("t2_irq", bus.irq, 1);
    chk("t2_tie_id", bus.claim_id, 3);
    bus.claim = 1; bus.src_irq = 8'h20; cyc(); bus.claim = 0;
    chk("t2_svc_id", bus.claim_id, 3);
    bus.complete = 1; bus.complete_id = 4'd3; cyc(); bus.complete = 0;
    chk("t2_irq_m1", bus.irq, 1);
    chk("t2_next_id", bus.claim_id, 6);
    bus.claim = 1; bus.src_irq = 8'h00; cyc(); bus.claim = 0;
    bus.complete = 1; bus.complete_id = 4'd6; cyc(); bus.complete = 0;
    cyc(2);

    // Threshold masking
    wr(0, 2); wr(9, 2); wr(2, 2);
    bus.src_irq = 8'h02;
    cyc(3);
    chk("t3_masked_irq", bus.irq, 0);
    chk("t3_masked_id", bus.claim_id, 0);
    wr(2, 1);
    chk("t3_irq_w1", bus.irq, 0);
    cyc();
    chk("t3_irq_w2", bus.irq, 1);
    chk("t3_id", bus.claim_id, 2);
    bus.src_irq = 8'h00;
    cyc(3);

    // Mismatched complete
    wr(0, 1);
    bus.src_irq = 8'h01;
    cyc(2);
    chk("t4_irq", bus.irq, 1);
    bus.claim = 1; cyc(); bus.claim = 0;
    bus.complete = 1; bus.complete_id = 4'd4; cyc(); bus.complete = 0;
    chk("t4_bad_irq", bus.irq, 0);
    chk("t4_bad_id", bus.claim_id, 1);
    rd("t4_bad_active", 3, 1);
    bus.complete = 1; bus.complete_id = 4'd1; cyc(); bus.complete = 0;
    chk("t4_done_irq", bus.irq, 0);
    chk("t4_done_id", bus.claim_id, 0);
    cyc();
    chk("t4_rearm_irq", bus.irq, 1);

    // Reset while in service
    bus.claim = 1; cyc(); bus.claim = 0;
    chk("t5_svc_id", bus.claim_id, 1);
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("t5_irq", bus.irq, 0);
    chk("t5_id", bus.claim_id, 0);
    rd("t5_pend", 1, 0);
    rd("t5_en", 0, 0);
    rd("t5_prio0", 8, 0);
    bus.src_irq = 8'h00;
    cyc(2);

    // Claim + complete + config write in the same IDLE cycle
    wr(0, 1); wr(8, 3);
    bus.src_irq = 8'h01;
    cyc(2);
    chk("t6_irq", bus.irq, 1);
    bus.claim = 1; bus.complete = 1; bus.complete_id = 4'd1;
    bus.cfg_wr = 1; bus.cfg_addr = 6'd2; bus.cfg_wdata = 32'd7;
    cyc();
    bus.claim = 0; bus.complete = 0; bus.cfg_wr = 0;
    chk("t6_svc_id", bus.claim_id, 1);
    chk("t6_irq_low", bus.irq, 0);
    rd("t6_thr", 2, 7);
    bus.complete = 1; cyc(); bus.complete = 0;
    cyc(3);
    chk("t6_thr_blocks", bus.irq, 0);
    bus.src_irq = 8'h00;
    cyc(2);

    // Unmapped offsets and the last priority slot
    wr(5, 'hff); wr(15, 5);
    rd("t7_prio7", 15, 5);
    rd("t7_unmapped5", 5, 0);
    rd("t7_unmapped20", 20, 0);
`ifndef IRQ_CTRL_EDGE_EN
    rd("t7_edge_absent", 4, 0);
`endif

`ifdef IRQ_CTRL_EDGE_EN
    // Edge-triggered source 0
    wr(2, 0); wr(4, 1);
    bus.src_irq = 8'h01; cyc(); bus.src_irq = 8'h00;
    rd("t8_pend_pulse", 1, 1);
    cyc();
    chk("t8_irq", bus.irq, 1);
    cyc(3);
    rd("t8_pend_held", 1, 1);
    bus.claim = 1; bus.src_irq = 8'h01; cyc(); bus.claim = 0; bus.src_irq = 8'h00;
    rd("t8_pend_set_wins", 1, 1);
    chk("t8_svc_id", bus.claim_id, 1);
    wr(1, 1);
    rd("t8_pend_w1c", 1, 0);
    bus.complete = 1; bus.complete_id = 4'd1; cyc(); bus.complete = 0;
    cyc(2);
    chk("t8_idle_irq", bus.irq, 0);
`endif

    cyc(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Parametrised multi-source interrupt controller that replaces the core's single `interrupt` pin with NUM_SRC prioritised, maskable sources. Sits between peripheral interrupt lines and the `riscv` top. Drives the core's interrupt input from the highest-priority eligible pending source. Provides a claim/complete handshake so the trap handler learns the source ID and the controller holds off further requests until the handler finishes.

## Interface
- NUM_SRC, 8: number of interrupt sources, 1..31; source line i has ID i+1, and ID 0 means "none".
- PRIO_W, 3: priority field width; priority 0 means never interrupt.
- ID_W, $clog2(NUM_SRC+1): width of source IDs.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- src_irq  in  NUM_SRC  raw interrupt lines, synchronous to clk.
- cfg_wr  in  1  configuration write strobe.
- cfg_addr  in  6  word offset of the configuration register.
- cfg_wdata  in  `RF_XLEN`  configuration write data.
- cfg_rdata  out  `RF_XLEN`  combinational read data for cfg_addr.
- irq  out  1  interrupt request to the core.
- claim  in  1  one-cycle pulse: the handler takes the current interrupt.
- claim_id  out  ID_W  ID of the currently selected source, or 0.
- complete  in  1  one-cycle pulse: the handler has finished.
- complete_id  in  ID_W  ID being completed.

## Operation
- Register map:
  - 0 = enable mask, bits [NUM_SRC-1:0].
  - 1 = pending, read-only.
  - 2 = threshold, [PRIO_W-1:0].
  - 3 = active ID, read-only.
  - 8+i = priority of source i.
  - Reads of unmapped offsets return 0. Writes to them are ignored.
- Pending:
  - Level mode: pending[i] is set from src_irq[i] each cycle.
  - A source is never pending while it is the active (in-service) source.
- Eligibility: pending & enable & (prio > threshold).
- Arbitration:
  - The highest priority wins.
  - On equal priority, the lowest index wins.
  - The result is registered into best_id / best_prio every cycle.
- FSM:
  - IDLE → SERVICE on claim && irq. The active ID latches claim_id, and pending[active] is cleared.
  - SERVICE → IDLE on complete && complete_id == active ID.
  - A complete with a mismatched ID is ignored.
  - A claim while irq=0 is ignored and changes no state.
- irq = (state==IDLE) && best_prio > threshold, registered.
- claim_id = best_id while in IDLE; it equals the active ID while in SERVICE.
- A configuration write in the same cycle as a claim: the claim uses the old values, and the write takes effect next cycle.
- Reset mid-service: FSM → IDLE. Enable, threshold, priorities, pending and the active ID all return to 0.

## Timing
- Reset values:
  - irq=0.
  - claim_id=0.
  - cfg_rdata reflects all-zero registers.
- Latency: src_irq rises in cycle N → pending in N+1 → irq high in N+2.
- irq falls in the cycle after an accepted claim.
- After a matching complete in cycle M, a newly eligible source can raise irq no earlier than M+1, with best_id already registered.
- A threshold or enable change suppresses or raises irq 2 cycles after the write cycle.
- Simultaneous claim and complete in IDLE: the complete is ignored and the claim is accepted.

## Configuration
- `IRQ_CTRL_EDGE_EN` defined:
  - Adds register 4, the edge-mode mask. A 1 bit makes that source rising-edge triggered.
  - An edge source's pending bit is set by a rising edge, using the previous sample held in a register.
  - That bit is cleared only by a claim of that source.
  - A new edge in the same cycle as its own claim leaves pending set; set wins.
  - Writing a 1 to a pending bit of an edge source clears it.
- Undefined:
  - All sources are level-triggered.
  - Register 4 reads 0.
  - There is no edge-detect flop.

## Structure
- Package `irq_pkg` holds:
  - the FSM enum (IDLE, SERVICE);
  - the register offset localparams;
  - the priority and ID typedefs.
- Sub-module `irq_arbiter`: a parametrised combinational priority-compare tree that takes the eligible mask and priority vector and returns (id, prio). It is instantiated once.
- The top module holds the config registers, the pending logic, the FSM and the output registers.

## Test plan
- Reset, then enable=0x01, prio[0]=3, threshold=0, and src_irq[0] raised in cycle N → irq=1 at N+2 and claim_id=1. A claim → irq=0 next cycle. complete_id=1 → IDLE.
- Tie-break: src 2 and src 5 both prio 4, threshold 1, both asserted → claim_id=3. After claim and complete with src 2 deasserted → claim_id=6.
- Threshold masking: prio=2 and threshold=2 → irq stays 0. Then write threshold=1 → irq=1 two cycles later.
- Mismatched complete: src 0 in service and complete_id=4 → remains SERVICE, irq=0. Then complete_id=1 → IDLE.
- Synchronous rst in SERVICE with src_irq still high → next cycle irq=0, claim_id=0, pending reads 0.
- With `IRQ_CTRL_EDGE_EN`: edge mask bit 0 set and a single-cycle pulse on src_irq[0] → pending stays 1 until claimed. A second pulse in the same cycle as the claim → pending still 1.
